// File: rtl/load_scoreboard_if.sv
// load_scoreboard_if: issue, memory-response, hazard-check and writeback signals of the load scoreboard
interface load_scoreboard_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_funct3;
  logic [1:0]  issue_off;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        chk_rs1_en;
  logic        chk_rs2_en;
  logic [4:0]  chk_rd;
  logic        chk_rd_en;
  logic        interlock;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        idle;
  logic        err;
  modport master (
    output issue_valid, issue_rd, issue_funct3, issue_off, resp_valid, resp_data,
           chk_rs1, chk_rs2, chk_rs1_en, chk_rs2_en, chk_rd, chk_rd_en,
    input  issue_ready, interlock, wb_valid, wb_rd, wb_data, idle, err
  );
  modport slave (
    input  issue_valid, issue_rd, issue_funct3, issue_off, resp_valid, resp_data,
           chk_rs1, chk_rs2, chk_rs1_en, chk_rs2_en, chk_rd, chk_rd_en,
    output issue_ready, interlock, wb_valid, wb_rd, wb_data, idle, err
  );
endinterface

// File: rtl/load_scoreboard.sv
// load_scoreboard: in-order queue of outstanding loads with decode interlock and extended registered writeback
module load_scoreboard #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  load_scoreboard_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } entry_t;
  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  head_q, tail_q;
  logic [AW:0]    count_q, count_d;
  logic           wb_valid_q, wb_valid_d;
  logic [4:0]     wb_rd_q, wb_rd_d;
  logic [31:0]    wb_data_q, wb_data_d;
  logic           err_q, err_d;
  logic           push, pop;
  entry_t         head_e;
  logic [7:0]     b;
  logic [15:0]    h;
  logic [31:0]    ext;
  logic [31:0]    busy;
  logic [AW-1:0]  rel;
  assign bus.issue_ready = count_q != (AW+1)'(DEPTH);
  assign push = bus.issue_valid && bus.issue_ready;
  assign pop = bus.resp_valid && count_q != '0;
  assign head_e = mem_q[head_q];
  assign b = 8'(bus.resp_data >> {head_e.off, 3'b000});
  assign h = head_e.off[1] ? bus.resp_data[31:16] : bus.resp_data[15:0];
  assign ext = head_e.f3 == 3'b000 ? {{24{b[7]}}, b} :
               head_e.f3 == 3'b001 ? {{16{h[15]}}, h} :
               head_e.f3 == 3'b100 ? {24'b0, b} :
               head_e.f3 == 3'b101 ? {16'b0, h} : bus.resp_data;
  always_comb begin
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wb_valid_d = pop && head_e.rd != 5'd0;
    wb_rd_d = pop ? head_e.rd : wb_rd_q;
    wb_data_d = pop ? ext : wb_data_q;
    err_d = err_q || (bus.issue_valid && !bus.issue_ready) || (bus.resp_valid && count_q == '0);
  end
  // busy[r]: r is still owed a write by a queued entry, the issuing load, or the pending writeback
  always_comb begin
    busy = '0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = AW'(i) - head_q;
      if ({1'b0, rel} < count_q) busy[mem_q[i].rd] = 1'b1;
    end
    if (push) busy[bus.issue_rd] = 1'b1;
    if (wb_valid_q) busy[wb_rd_q] = 1'b1;
    busy[0] = 1'b0;
  end
  assign bus.interlock = (bus.chk_rs1_en && busy[bus.chk_rs1]) ||
                         (bus.chk_rs2_en && busy[bus.chk_rs2]) ||
                         (bus.chk_rd_en && busy[bus.chk_rd]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) mem_q[tail_q] <= '{rd: bus.issue_rd, f3: bus.issue_funct3, off: bus.issue_off};
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q <= err_d;
    end
  end
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign bus.idle = count_q == '0 && !wb_valid_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_load_scoreboard.sv
// tb_load_scoreboard: directed and randomized checks of load_scoreboard against a queue-based reference model
module tb_load_scoreboard;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;
  ld_t         mq[$];
  logic        m_wbv;
  logic [4:0]  m_wbr;
  logic [31:0] m_wbd;
  logic        m_err;
  load_scoreboard_if bus();
  load_scoreboard #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0] by;
    logic [15:0] hw;
    by = 8'(w >> (8 * int'(off)));
    hw = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return 32'($signed(by));
      3'b001: return 32'($signed(hw));
      3'b100: return 32'(by);
      3'b101: return 32'(hw);
      default: return w;
    endcase
  endfunction
  function automatic bit m_push();
    return bus.issue_valid && mq.size() != DEPTH;
  endfunction
  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 0;
    foreach (mq[i]) if (mq[i].rd == r) return 1;
    if (m_push() && bus.issue_rd == r) return 1;
    if (m_wbv && m_wbr == r) return 1;
    return 0;
  endfunction
  task automatic model_reset();
    mq.delete();
    m_wbv = 0;
    m_wbr = '0;
    m_wbd = '0;
    m_err = 0;
  endtask
  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_rd = '0; bus.issue_funct3 = 3'b010; bus.issue_off = '0;
    bus.resp_valid = 0; bus.resp_data = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
    bus.chk_rs1_en = 0; bus.chk_rs2_en = 0; bus.chk_rd_en = 0;
  endtask
  task automatic cycle();
    bit ex_il;
    bit pu, po;
    ld_t e;
    #1;
    ex_il = (bus.chk_rs1_en && pending(bus.chk_rs1)) || (bus.chk_rs2_en && pending(bus.chk_rs2)) ||
            (bus.chk_rd_en && pending(bus.chk_rd));
    chk("issue_ready", 32'(bus.issue_ready), 32'(mq.size() != DEPTH));
    chk("interlock", 32'(bus.interlock), 32'(ex_il));
    chk("idle", 32'(bus.idle), 32'(mq.size() == 0 && !m_wbv));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
    if (m_wbv) begin
      chk("wb_rd", 32'(bus.wb_rd), 32'(m_wbr));
      chk("wb_data", bus.wb_data, m_wbd);
    end
    @(posedge clk);
    pu = m_push();
    po = bus.resp_valid && mq.size() != 0;
    if ((bus.issue_valid && !pu) || (bus.resp_valid && mq.size() == 0)) m_err = 1;
    m_wbv = 0;
    if (po) begin
      e = mq.pop_front();
      m_wbv = e.rd != 0;
      m_wbr = e.rd;
      m_wbd = extend(e.f3, e.off, bus.resp_data);
    end
    if (pu) mq.push_back('{rd: bus.issue_rd, f3: bus.issue_funct3, off: bus.issue_off});
    #1;
  endtask
  task automatic do_reset();
    idle_inputs();
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("rst_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_wbv", 32'(bus.wb_valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_il", 32'(bus.interlock), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    bus.issue_valid = 1; bus.issue_rd = rd; bus.issue_funct3 = f3; bus.issue_off = off;
    cycle();
    bus.issue_valid = 0;
  endtask
  task automatic respond(input logic [31:0] d);
    bus.resp_valid = 1; bus.resp_data = d;
    cycle();
    bus.resp_valid = 0;
  endtask
  task automatic ext_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] d, input logic [31:0] exp);
    issue(5'd9, f3, off);
    respond(d);
    chk(tag, bus.wb_data, exp);
    cycle();
  endtask
  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    // load-use: rd 5 blocks rs1 5 until the cycle after writeback
    bus.chk_rs1 = 5'd5; bus.chk_rs1_en = 1;
    bus.issue_valid = 1; bus.issue_rd = 5'd5; bus.issue_funct3 = 3'b010;
    #1 chk("lu_il0", 32'(bus.interlock), 32'd1);
    cycle();
    bus.issue_valid = 0;
    cycle();
    cycle();
    respond(32'hDEADBEEF);
    chk("lu_wbv", 32'(bus.wb_valid), 32'd1);
    chk("lu_wbrd", 32'(bus.wb_rd), 32'd5);
    chk("lu_data", bus.wb_data, 32'hDEADBEEF);
    chk("lu_il_wb", 32'(bus.interlock), 32'd1);
    cycle();
    chk("lu_il_rel", 32'(bus.interlock), 32'd0);
    idle_inputs();
    ext_case("lb", 3'b000, 2'd3, 32'h80FF0000, 32'hFFFFFF80);
    ext_case("lhu", 3'b101, 2'd2, 32'h80FF1234, 32'h000080FF);
    ext_case("lh", 3'b001, 2'd0, 32'h0000F00D, 32'hFFFFF00D);
    ext_case("lbu", 3'b100, 2'd1, 32'h0000A500, 32'h000000A5);
    // full queue: refused issue with same-cycle response
    for (int r = 1; r <= 4; r++) issue(5'(r), 3'b010, 2'd0);
    chk("full_ready", 32'(bus.issue_ready), 32'd0);
    bus.issue_valid = 1; bus.issue_rd = 5'd9; bus.resp_valid = 1; bus.resp_data = 32'h11;
    cycle();
    idle_inputs();
    chk("full_err", 32'(bus.err), 32'd1);
    chk("full_wbrd1", 32'(bus.wb_rd), 32'd1);
    chk("full_ready2", 32'(bus.issue_ready), 32'd1);
    for (int r = 2; r <= 4; r++) begin
      bus.resp_valid = 1; bus.resp_data = 32'(r);
      cycle();
      chk("b2b_wbv", 32'(bus.wb_valid), 32'd1);
      chk("b2b_wbrd", 32'(bus.wb_rd), 32'(r));
    end
    idle_inputs();
    cycle();
    // x0 destination never interlocks nor writes back
    bus.chk_rs1 = 5'd0; bus.chk_rs1_en = 1;
    bus.issue_valid = 1; bus.issue_rd = 5'd0;
    #1 chk("x0_il", 32'(bus.interlock), 32'd0);
    cycle();
    idle_inputs();
    respond(32'h1234);
    chk("x0_wbv", 32'(bus.wb_valid), 32'd0);
    chk("x0_idle", 32'(bus.idle), 32'd1);
    do_reset();
    respond(32'h55);
    chk("empty_err", 32'(bus.err), 32'd1);
    chk("empty_wbv", 32'(bus.wb_valid), 32'd0);
    issue(5'd7, 3'b010, 2'd0);
    bus.chk_rd = 5'd7; bus.chk_rd_en = 1;
    #1 chk("waw_il", 32'(bus.interlock), 32'd1);
    do_reset();
    cycle();
    chk("post_rst_wbv", 32'(bus.wb_valid), 32'd0);
    for (int n = 0; n < 600; n++) begin
      bus.issue_valid = $urandom_range(0, 99) < 55;
      bus.issue_rd = 5'($urandom_range(0, 7));
      bus.issue_funct3 = 3'($urandom);
      bus.issue_off = 2'($urandom);
      bus.resp_valid = $urandom_range(0, 99) < 45;
      bus.resp_data = $urandom;
      bus.chk_rs1 = 5'($urandom_range(0, 7));
      bus.chk_rs2 = 5'($urandom_range(0, 7));
      bus.chk_rd = 5'($urandom_range(0, 7));
      bus.chk_rs1_en = 1'($urandom);
      bus.chk_rs2_en = 1'($urandom);
      bus.chk_rd_en = 1'($urandom);
      cycle();
      if (n == 300) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
